lector_fifos_salida: RTL and testbench



---
 rtl/lector_fifos_salida_if.sv | 37 +++
 rtl/lector_fifos_salida.sv | 160 ++++++++++++++++
 tb/tb_lector_fifos_salida.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lector_fifos_salida_if.sv
// rtl/lector_fifos_salida_if.sv - FIFO-side and result-side signal bundle of the output FIFO reader
interface lector_fifos_salida_if #(
    parameter int data_width = 10,
    parameter int cnt_width  = 8
);
    logic [7:0]            empty_fifos;
    logic [data_width-1:0] FIFO_data_out4;
    logic [data_width-1:0] FIFO_data_out5;
    logic [data_width-1:0] FIFO_data_out6;
    logic [data_width-1:0] FIFO_data_out7;
    logic                  hold;
    logic                  pop4;
    logic                  pop5;
    logic                  pop6;
    logic                  pop7;
    logic [data_width-1:0] data_out;
    logic                  data_valid;
    logic [1:0]            chan_out;
    logic [cnt_width-1:0]  cnt4;
    logic [cnt_width-1:0]  cnt5;
    logic [cnt_width-1:0]  cnt6;
    logic [cnt_width-1:0]  cnt7;
    logic                  dest_err;
    logic [cnt_width-1:0]  err_cnt;

    modport master (
        input  empty_fifos, FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7, hold,
        output pop4, pop5, pop6, pop7, data_out, data_valid, chan_out,
        output cnt4, cnt5, cnt6, cnt7, dest_err, err_cnt
    );

    modport slave (
        output empty_fifos, FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7, hold,
        input  pop4, pop5, pop6, pop7, data_out, data_valid, chan_out,
        input  cnt4, cnt5, cnt6, cnt7, dest_err, err_cnt
    );
endinterface

// File: rtl/lector_fifos_salida.sv
// rtl/lector_fifos_salida.sv - round-robin reader of output FIFOs 4-7 with per-channel counters
// Define LECTOR_DEST_CHECK_EN to build the destination-field check (dest_err/err_cnt).
module lector_fifos_salida #(
    parameter int data_width = 10,
    parameter int cnt_width  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    lector_fifos_salida_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, CAPTURE = 2'd2} state_t;

    localparam logic [cnt_width-1:0] CNT_MAX = '1;
    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            sel_q, sel_d;
    logic [3:0]            pop_q, pop_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [1:0]            chan_q, chan_d;
    logic [cnt_width-1:0]  cnt_q [4];
    logic [cnt_width-1:0]  cnt_d [4];

    logic [3:0]            nonempty;
    logic [1:0]            base;
    logic [1:0]            pick;
    logic                  found;
    logic                  eligible;
    logic [data_width-1:0] word;
    logic                  unused_empty;

    assign nonempty     = ~bus.empty_fifos[7:4];
    assign unused_empty = ^bus.empty_fifos[3:0];

    // In CAPTURE the pointer has not been written yet, so search from sel+1 directly.
    always_comb begin
        base     = (state_q == CAPTURE) ? sel_q + 2'd1 : ptr_q;
        pick     = base;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && nonempty[base + 2'(i)]) begin
                pick  = base + 2'(i);
                found = 1'b1;
            end
        end
        eligible = found && !bus.hold;
    end

    always_comb begin
        word = bus.FIFO_data_out4;
        case (sel_q)
            2'd1:    word = bus.FIFO_data_out5;
            2'd2:    word = bus.FIFO_data_out6;
            2'd3:    word = bus.FIFO_data_out7;
            default: word = bus.FIFO_data_out4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        pop_d   = 4'b0000;
        data_d  = data_q;
        valid_d = 1'b0;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = POP;
                    sel_d   = pick;
                    pop_d   = 4'b0001 << pick;
                end
            end
            POP: state_d = CAPTURE;
            CAPTURE: begin
                data_d  = word;
                chan_d  = sel_q;
                valid_d = 1'b1;
                if (cnt_q[sel_q] != CNT_MAX) begin
                    cnt_d[sel_q] = cnt_q[sel_q] + CNT_ONE;
                end
                ptr_d = sel_q + 2'd1;
                if (eligible) begin
                    state_d = POP;
                    sel_d   = pick;
                    pop_d   = 4'b0001 << pick;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            pop_q   <= 4'b0000;
            data_q  <= '0;
            valid_q <= 1'b0;
            chan_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            pop_q   <= pop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LECTOR_DEST_CHECK_EN
    logic                 err_q;
    logic [cnt_width-1:0] err_cnt_q;
    logic                 mismatch;

    assign mismatch = (state_q == CAPTURE) && (word[data_width-1 -: 2] != sel_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (mismatch) begin
            err_q <= 1'b1;
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.dest_err = err_q;
    assign bus.err_cnt  = err_cnt_q;
`else
    assign bus.dest_err = 1'b0;
    assign bus.err_cnt  = '0;
`endif

    assign bus.pop4       = pop_q[0];
    assign bus.pop5       = pop_q[1];
    assign bus.pop6       = pop_q[2];
    assign bus.pop7       = pop_q[3];
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.chan_out   = chan_q;
    assign bus.cnt4       = cnt_q[0];
    assign bus.cnt5       = cnt_q[1];
    assign bus.cnt6       = cnt_q[2];
    assign bus.cnt7       = cnt_q[3];
endmodule

// File: tb/tb_lector_fifos_salida.sv
// tb/tb_lector_fifos_salida.sv - bench for lector_fifos_salida: FIFO model, arbitration scoreboard, vector table
module tb_lector_fifos_salida;
    localparam int DW      = 10;
    localparam int CW      = 8;
    localparam int CNT_MAX = 255;
`ifdef LECTOR_DEST_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lector_fifos_salida_if #(.data_width(DW), .cnt_width(CW)) bus ();
    lector_fifos_salida #(.data_width(DW), .cnt_width(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fq [4][$];
    logic [DW-1:0] fd [4];

    // Protocol-level reference: pop decisions, capture pipeline and running totals.
    logic [3:0]    act_pop_prev;
    logic          sb1_v, sb2_v;
    int            sb1_ch, sb2_ch;
    logic [DW-1:0] sb2_w;
    int            rr_ptr;
    int            cnt_exp [4];
    int            err_cnt_exp;
    logic          err_exp;
    logic [DW-1:0] data_exp;
    int            chan_exp;
    logic [3:0]    last_pop;
    logic          last_valid;
    int            cyc;

    typedef struct {
        int            ch;
        logic [DW-1:0] word;
        logic [3:0]    exp_pop;
        int            exp_chan;
        logic          exp_mis;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] pop_vec();
        return {bus.pop7, bus.pop6, bus.pop5, bus.pop4};
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int c);
        case (c)
            1:       return bus.cnt5;
            2:       return bus.cnt6;
            3:       return bus.cnt7;
            default: return bus.cnt4;
        endcase
    endfunction

    function automatic int ch_of(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic drive_flags();
        logic [3:0] e;
        for (int c = 0; c < 4; c++) e[c] = (fq[c].size() == 0);
        bus.empty_fifos    = {e, 4'hF};
        bus.FIFO_data_out4 = fd[0];
        bus.FIFO_data_out5 = fd[1];
        bus.FIFO_data_out6 = fd[2];
        bus.FIFO_data_out7 = fd[3];
    endtask

    task automatic push(input int ch, input logic [DW-1:0] w);
        fq[ch].push_back(w);
        drive_flags();
    endtask

    task automatic step();
        logic          h, r, exp_valid, found;
        logic [3:0]    ne, pnow, exp_pop;
        int            pick, vch;
        logic [DW-1:0] vw;
        h = bus.hold;
        r = reset;
        ne = ~bus.empty_fifos[7:4];
        @(posedge clk);
        #1;
        cyc++;
        pnow    = pop_vec();
        exp_pop = 4'b0000;
        pick    = 0;
        found   = 1'b0;
        // A pop may only follow a non-pop cycle with hold low and some FIFO non-empty.
        if (!r && !sb1_v && !h && ne != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (!found && ne[(rr_ptr + i) % 4]) begin
                    pick  = (rr_ptr + i) % 4;
                    found = 1'b1;
                end
            end
            exp_pop[pick] = 1'b1;
            rr_ptr = (pick + 1) % 4;
        end
        exp_valid = sb2_v && !r;
        vch = sb2_ch;
        vw  = sb2_w;
        if (exp_valid) begin
            data_exp = vw;
            chan_exp = vch;
            if (cnt_exp[vch] < CNT_MAX) cnt_exp[vch]++;
            if (CHECK_EN && vw[DW-1 -: 2] != 2'(vch)) begin
                err_exp = 1'b1;
                if (err_cnt_exp < CNT_MAX) err_cnt_exp++;
            end
        end
        if (r) begin
            for (int c = 0; c < 4; c++) cnt_exp[c] = 0;
            err_exp     = 1'b0;
            err_cnt_exp = 0;
            data_exp    = '0;
            chan_exp    = 0;
            rr_ptr      = 0;
        end
        chk("pop", pnow, exp_pop);
        chk("data_valid", bus.data_valid, exp_valid);
        chk("data_out", bus.data_out, data_exp);
        chk("chan_out", bus.chan_out, chan_exp);
        chk("cnt4", bus.cnt4, cnt_exp[0]);
        chk("cnt5", bus.cnt5, cnt_exp[1]);
        chk("cnt6", bus.cnt6, cnt_exp[2]);
        chk("cnt7", bus.cnt7, cnt_exp[3]);
        chk("dest_err", bus.dest_err, err_exp);
        chk("err_cnt", bus.err_cnt, err_cnt_exp);
        for (int c = 0; c < 4; c++) begin
            if (act_pop_prev[c]) begin
                chk("pop_nonempty", fq[c].size() != 0, 1);
                if (fq[c].size() != 0) fd[c] = fq[c].pop_front();
            end
        end
        sb2_v        = sb1_v && !r;
        sb2_ch       = sb1_ch;
        sb2_w        = fd[sb1_ch];
        sb1_v        = (exp_pop != 4'b0000);
        sb1_ch       = pick;
        act_pop_prev = pnow;
        last_pop     = pnow;
        last_valid   = bus.data_valid;
        drive_flags();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.hold = 1'b0;
        step();
        step();
        for (int c = 0; c < 4; c++) fq[c].delete();
        drive_flags();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int            pop_at, val_at, n, pc, vc;
        logic [3:0]    popv;
        int            order[$];
        int            times[$];
        logic [DW-1:0] w;
        int            ch;

        reset        = 1'b1;
        bus.hold     = 1'b0;
        act_pop_prev = 4'b0000;
        sb1_v = 1'b0; sb2_v = 1'b0; sb1_ch = 0; sb2_ch = 0; sb2_w = '0;
        rr_ptr = 0; err_cnt_exp = 0; err_exp = 1'b0; data_exp = '0; chan_exp = 0; cyc = 0;
        for (int c = 0; c < 4; c++) begin
            cnt_exp[c] = 0;
            fd[c]      = '0;
        end
        last_pop   = 4'b0000;
        last_valid = 1'b0;
        drive_flags();

        vecs[0] = '{0, 10'b0010010000, 4'b0001, 0, 1'b0};
        vecs[1] = '{0, 10'b0100000001, 4'b0001, 0, 1'b1};
        vecs[2] = '{1, 10'b0111111111, 4'b0010, 1, 1'b0};
        vecs[3] = '{2, 10'b1000000000, 4'b0100, 2, 1'b0};
        vecs[4] = '{3, 10'b1111000011, 4'b1000, 3, 1'b0};
        vecs[5] = '{3, 10'b0000000011, 4'b1000, 3, 1'b1};

        // Reset then idle with every FIFO empty.
        do_reset();
        pc = 0; vc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_pop != 4'b0000) pc++;
            if (last_valid) vc++;
        end
        chk("idle_pops", pc, 0);
        chk("idle_valids", vc, 0);

        foreach (vecs[i]) begin
            do_reset();
            push(vecs[i].ch, vecs[i].word);
            pop_at = -1; val_at = -1; popv = 4'b0000;
            for (int s = 1; s <= 6; s++) begin
                step();
                if (last_pop != 4'b0000 && pop_at < 0) begin
                    pop_at = s;
                    popv   = last_pop;
                end
                if (last_valid && val_at < 0) val_at = s;
            end
            chk("vec_pop_vec", popv, vecs[i].exp_pop);
            chk("vec_pop_cycle", pop_at, 1);
            chk("vec_valid_cycle", val_at, 3);
            chk("vec_data_out", bus.data_out, vecs[i].word);
            chk("vec_chan_out", bus.chan_out, vecs[i].exp_chan);
            chk("vec_cnt", cnt_of(vecs[i].ch), 1);
            chk("vec_dest_err", bus.dest_err, CHECK_EN ? vecs[i].exp_mis : 1'b0);
            chk("vec_err_cnt", bus.err_cnt, (CHECK_EN && vecs[i].exp_mis) ? 1 : 0);
        end

        // Round-robin fairness with all four FIFOs loaded.
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) push(c, {2'(c), 8'($urandom)});
        for (int i = 0; i < 30; i++) begin
            step();
            if (last_pop != 4'b0000) begin
                order.push_back(ch_of(last_pop));
                times.push_back(cyc);
            end
        end
        chk("rr_count", order.size(), 12);
        for (int i = 0; i < order.size(); i++) begin
            chk("rr_order", order[i], i % 4);
            if (i > 0) chk("rr_spacing", times[i] - times[i-1], 2);
        end
        for (int c = 0; c < 4; c++) chk("rr_cnt", cnt_of(c), 3);

        // Back-pressure raised during the POP cycle.
        do_reset();
        push(1, 10'b0100000001);
        push(1, 10'b0100000010);
        n = 0;
        while (last_pop == 4'b0000 && n < 5) begin
            step();
            n++;
        end
        chk("bp_first_pop", last_pop, 4'b0010);
        bus.hold = 1'b1;
        pc = 0; vc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_pop != 4'b0000) pc++;
            if (last_valid) vc++;
        end
        chk("bp_pops_during_hold", pc, 0);
        chk("bp_capture_done", vc, 1);
        bus.hold = 1'b0;
        step();
        chk("bp_resume_pop", last_pop, 4'b0010);
        for (int i = 0; i < 6; i++) step();

        // Reset asserted in the CAPTURE cycle.
        do_reset();
        push(0, 10'b0000000001);
        push(0, 10'b0000000010);
        push(1, 10'b0100000011);
        n = 0;
        while (last_pop == 4'b0000 && n < 5) begin
            step();
            n++;
        end
        chk("rst_first_pop", last_pop, 4'b0001);
        step();
        reset = 1'b1;
        step();
        chk("rst_valid", last_valid, 1'b0);
        chk("rst_pop", last_pop, 4'b0000);
        chk("rst_cnt4", bus.cnt4, 0);
        reset = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (last_pop == 4'b0000 && n < 5);
        chk("rst_restart_pop", last_pop, 4'b0001);
        for (int i = 0; i < 8; i++) step();

        // Random traffic, hold and occasional reset.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                ch = $urandom_range(0, 3);
                w  = 10'($urandom);
                if ($urandom_range(0, 3) != 0) w[DW-1 -: 2] = 2'(ch);
                push(ch, w);
            end
            bus.hold = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            step();
        end
        reset    = 1'b0;
        bus.hold = 1'b0;
        for (int i = 0; i < 60; i++) step();

        // Saturation of cnt4 and err_cnt.
        do_reset();
        for (int i = 0; i < 260; i++) push(0, {2'b01, 8'(i)});
        for (int i = 0; i < 540; i++) step();
        chk("sat_cnt4", bus.cnt4, CNT_MAX);
        chk("sat_err_cnt", bus.err_cnt, CHECK_EN ? CNT_MAX : 0);
        chk("sat_dest_err", bus.dest_err, CHECK_EN);
        chk("sat_drained", fq[0].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
